// File: rtl/multdiv_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes), one bit per cycle.
// Optional MULTDIV_EARLY_DIV0_EN: a zero divisor finishes one edge after the start edge.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opd_q;
    logic             qm1_q;
    logic             neg_q;
    logic             div0_q;
    logic             ovf_q;
    logic [WIDTH-1:0] res_q;
    logic             exc_q;
    logic             rdy_q;

    logic [WIDTH:0]   opd_sx;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   mul_acc_d;
    logic [WIDTH-1:0] mul_lo_d;
    logic             mul_exc;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_acc_d;
    logic             div_ge;
    logic [WIDTH-1:0] div_lo_d;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_finish;

    // acc/lo double as Booth product (hi, lo) and as divider (remainder, quotient).
    always_comb begin
        opd_sx    = {opd_q[WIDTH-1], opd_q};
        booth_sum = acc_q;
        case ({lo_q[0], qm1_q})
            2'b10:   booth_sum = acc_q - opd_sx;
            2'b01:   booth_sum = acc_q + opd_sx;
            default: booth_sum = acc_q;
        endcase
        mul_acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
        mul_exc   = (mul_acc_d[WIDTH-1:0] != {WIDTH{mul_lo_d[WIDTH-1]}});

        div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opd_q});
        div_acc_d = div_ge ? (div_shift - {1'b0, opd_q}) : div_shift;
        div_lo_d  = {lo_q[WIDTH-2:0], div_ge};
        quot      = neg_q ? (-div_lo_d) : div_lo_d;

        abs_a = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;
    end

`ifdef MULTDIV_EARLY_DIV0_EN
    assign div_finish = (cnt_q == CNT_LAST) || div0_q;
`else
    assign div_finish = (cnt_q == CNT_LAST);
`endif

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            qm1_q   <= 1'b0;
            neg_q   <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_MULT) begin
                state_q <= MULT;
                cnt_q   <= '0;
                acc_q   <= '0;
                lo_q    <= data_operandB;
                opd_q   <= data_operandA;
                qm1_q   <= 1'b0;
            end else if (ctrl_DIV) begin
                state_q <= DIV;
                cnt_q   <= '0;
                acc_q   <= '0;
                lo_q    <= abs_a;
                opd_q   <= abs_b;
                neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div0_q  <= (data_operandB == '0);
                ovf_q   <= (data_operandA == MOST_NEG) && (data_operandB == '1);
            end else begin
                case (state_q)
                    MULT: begin
                        acc_q <= mul_acc_d;
                        lo_q  <= mul_lo_d;
                        qm1_q <= lo_q[0];
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= DONE;
                            res_q   <= mul_lo_d;
                            exc_q   <= mul_exc;
                            rdy_q   <= 1'b1;
                        end
                    end
                    DIV: begin
                        acc_q <= div_acc_d;
                        lo_q  <= div_lo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (div_finish) begin
                            // MOST_NEG / -1 wraps to MOST_NEG naturally; only the flag is extra.
                            state_q <= DONE;
                            res_q   <= div0_q ? '0 : quot;
                            exc_q   <= div0_q | ovf_q;
                            rdy_q   <= 1'b1;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized ops against a behavioural model.
module tb_multdiv_unit;

    localparam logic [31:0] MIN32 = 32'h8000_0000;
`ifdef MULTDIV_EARLY_DIV0_EN
    localparam int DIV0_EDGE = 2;
`else
    localparam int DIV0_EDGE = 33;
`endif

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {exception, result} from plain 64-bit arithmetic.
    function automatic logic [32:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, p, ext;
        logic [31:0] lo;
        pa  = $signed(a);
        pb  = $signed(b);
        p   = pa * pb;
        lo  = p[31:0];
        ext = $signed(lo);
        return {(ext != p), lo};
    endfunction

    function automatic logic [32:0] f_div(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, q, ext;
        logic [31:0] lo;
        if (b == 32'd0) return {1'b1, 32'd0};
        pa  = $signed(a);
        pb  = $signed(b);
        q   = pa / pb;
        lo  = q[31:0];
        ext = $signed(lo);
        return {(ext != q), lo};
    endfunction

    // Behavioural model: pending op with edges-until-strobe, plus held outputs.
    bit          pend = 1'b0;
    int          edges_left = 0;
    logic [32:0] m_val = '0;
    logic [31:0] held_res = '0;
    bit          held_exc = 1'b0;
    bit          exp_rdy = 1'b0;

    always @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            pend <= 1'b0;
            edges_left <= 0;
            exp_rdy <= 1'b0;
            held_res <= '0;
            held_exc <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            exp_rdy <= 1'b0;
            pend <= 1'b1;
            if (ctrl_MULT) begin
                m_val <= f_mul(data_operandA, data_operandB);
                edges_left <= 32;
            end else begin
                m_val <= f_div(data_operandA, data_operandB);
                edges_left <= (data_operandB == 32'd0) ? DIV0_EDGE - 1 : 32;
            end
        end else if (pend && edges_left == 1) begin
            pend <= 1'b0;
            exp_rdy <= 1'b1;
            held_res <= m_val[31:0];
            held_exc <= m_val[32];
        end else begin
            exp_rdy <= 1'b0;
            if (pend) edges_left <= edges_left - 1;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk(64'(data_resultRDY), 64'(exp_rdy), "cyc_rdy");
            chk(64'(data_result), 64'(held_res), "cyc_res");
            chk(64'(data_exception), 64'(held_exc), "cyc_exc");
        end
    end

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = m;
        ctrl_DIV = d;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(input int start_edge, output int edge_n);
        edge_n = start_edge;
        while (!data_resultRDY && edge_n < 80) begin
            @(posedge clock);
            edge_n++;
            @(negedge clock);
        end
        if (!data_resultRDY) edge_n = -1;
    endtask

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input bit ee, input int eedge, input string nm);
        int e;
        start_op(m, d, a, b);
        wait_rdy(1, e);
        chk(64'(e), 64'(eedge), {nm, "_edge"});
        chk(64'(data_result), 64'(er), {nm, "_res"});
        chk(64'(data_exception), 64'(ee), {nm, "_exc"});
        @(negedge clock);
        chk(64'(data_resultRDY), 64'd0, {nm, "_strobe_len"});
        chk(64'(data_result), 64'(er), {nm, "_hold"});
    endtask

    initial begin
        int e, nstrobe, first_edge;
        logic [31:0] seen_res, a, b;
        bit m, d;

        chk(64'(f_div(32'd100, 32'hFFFF_FFF9)), {31'd0, 1'b0, 32'hFFFF_FFF2}, "model_div_100_m7");
        chk(64'(f_div(MIN32, 32'hFFFF_FFFF)), {31'd0, 1'b1, MIN32}, "model_div_min_m1");
        chk(64'(f_div(32'hFFFF_FFF9, 32'd2)), {31'd0, 1'b0, 32'hFFFF_FFFD}, "model_div_m7_2");
        chk(64'(f_mul(32'h0001_0000, 32'h0001_0000)), {31'd0, 1'b1, 32'd0}, "model_mul_ovf");

        #2 ctrl_reset = 1'b1;
        #1 cmp_en = 1'b1;
        chk(64'({data_resultRDY, data_exception, data_result}), 64'd0, "reset_outputs");
        repeat (3) @(negedge clock);
        ctrl_reset = 1'b0;

        run_op(1, 0, 32'd6, 32'd7, 32'd42, 1'b0, 33, "mul_6x7");
        run_op(1, 0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33, "mul_m3x5");
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 33, "mul_ovf");
        run_op(0, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33, "div_100_m7");
        run_op(0, 1, MIN32, 32'hFFFF_FFFF, MIN32, 1'b1, 33, "div_min_m1");
        run_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, DIV0_EDGE, "div_by0");
        run_op(1, 1, 32'd9, 32'd3, 32'd27, 1'b0, 33, "both_9_3");

        // Abort a multiply at edge 10 with a divide.
        start_op(1, 0, 32'd1234, 32'd5678);
        e = 1;
        while (e < 9) begin
            @(posedge clock);
            e++;
            @(negedge clock);
        end
        data_operandA = 32'd1000;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        nstrobe = 0;
        first_edge = -1;
        seen_res = '0;
        for (int k = 11; k <= 60; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) begin
                nstrobe++;
                if (first_edge < 0) begin
                    first_edge = k;
                    seen_res = data_result;
                end
            end
        end
        chk(64'(nstrobe), 64'd1, "abort_strobes");
        chk(64'(first_edge), 64'd42, "abort_edge");
        chk(64'(seen_res), 64'd142, "abort_quot");

        // Asynchronous reset just after edge 15 of a multiply.
        start_op(1, 0, 32'd77, 32'd11);
        e = 1;
        while (e < 15) begin
            @(posedge clock);
            e++;
        end
        #2 ctrl_reset = 1'b1;
        #1 chk(64'({data_resultRDY, data_exception, data_result}), 64'd0, "async_reset_out");
        #4 ctrl_reset = 1'b0;
        nstrobe = 0;
        for (int k = 16; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) nstrobe++;
        end
        chk(64'(nstrobe), 64'd0, "reset_no_strobe");

        // Start held through reset is ignored, then accepted on the first edge after release.
        @(negedge clock);
        ctrl_reset = 1'b1;
        data_operandA = 32'd2;
        data_operandB = 32'd3;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_rdy(1, e);
        chk(64'(e), 64'd33, "post_reset_edge");
        chk(64'(data_result), 64'd6, "post_reset_res");

        // Randomized ops with random gaps; some complete, some are aborted.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = MIN32; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 200)) - 100); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            m = 1'($urandom_range(0, 1));
            d = m ? ($urandom_range(0, 3) == 0) : 1'b1;
            start_op(m, d, a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 30)) @(posedge clock);
            else repeat (34) @(posedge clock);
        end
        repeat (40) @(posedge clock);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
